// File: rtl/oflow_prev_frame_buffer_reader.sv
// Ping-pong previous-frame feature-line store with a paired-line replay engine.
// Optional sticky write-drop flag: define OFLOW_PREV_BUF_OVF_FLAG_EN.
`ifndef DATA_TO_PE_WIDTH
`define DATA_TO_PE_WIDTH 64
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif

module oflow_prev_frame_buffer_reader #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = `DATA_TO_PE_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           wr_frame_done,
    output logic                           wr_ready,
    input  logic                           start_read,
    input  logic                           control_for_read_new_line,
    output logic [DATA_W-1:0]              data_to_similarity_metric_0,
    output logic [DATA_W-1:0]              data_to_similarity_metric_1,
    output logic                           done_read,
    output logic [$clog2(DEPTH+1)-1:0]     prev_count
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
    ,
    output logic                           wr_overflow
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = CW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic [IW-1:0]     prev_count_q, prev_count_d;
    logic [IW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] lane0_q, lane0_d;
    logic [DATA_W-1:0] lane1_q, lane1_d;
    logic              done_q, done_d;

    logic              wr_acc;
    logic              do_swap;
    logic [IW-1:0]     rd_ptr_p1;
    logic [DATA_W-1:0] rd_line0, rd_line1;

    assign wr_ready   = ~swap_pending_q;
    assign prev_count = prev_count_q[CW-1:0];
    assign data_to_similarity_metric_0 = lane0_q;
    assign data_to_similarity_metric_1 = lane1_q;
    assign done_read  = done_q;

    assign rd_ptr_p1 = rd_ptr_q + IW'(1);
    // Read bank is the one not being written.
    assign rd_line0 = wr_bank_q ? bank0[rd_ptr_q[AW-1:0]]
                                : bank1[rd_ptr_q[AW-1:0]];
    assign rd_line1 = wr_bank_q ? bank0[rd_ptr_p1[AW-1:0]]
                                : bank1[rd_ptr_p1[AW-1:0]];

    always_comb begin
        wr_acc         = wr_en && !swap_pending_q && (wr_ptr_q < DEPTH_W);
        do_swap        = (state_q == S_IDLE) && (wr_frame_done || swap_pending_q);
        wr_ptr_d       = wr_ptr_q + CW'(wr_acc);
        wr_bank_d      = wr_bank_q;
        swap_pending_d = swap_pending_q;
        prev_count_d   = prev_count_q;
        if (do_swap) begin
            prev_count_d   = {1'b0, wr_ptr_q} + IW'(wr_acc);
            wr_bank_d      = ~wr_bank_q;
            wr_ptr_d       = '0;
            swap_pending_d = 1'b0;
        end else if (wr_frame_done) begin
            swap_pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        lane0_d  = lane0_q;
        lane1_d  = lane1_q;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_read) begin
                    rd_ptr_d = '0;
                    done_d   = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                lane0_d  = (rd_ptr_q < prev_count_q) ? rd_line0 : '0;
                lane1_d  = (rd_ptr_p1 < prev_count_q) ? rd_line1 : '0;
                rd_ptr_d = rd_ptr_q + IW'(2);
                done_d   = (rd_ptr_q + IW'(2)) >= prev_count_q;
                state_d  = S_PRESENT;
            end
            S_PRESENT: begin
                if (control_for_read_new_line)
                    state_d = done_q ? S_IDLE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_bank_q) bank1[wr_ptr_q[AW-1:0]] <= wr_data;
            else           bank0[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            wr_bank_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            prev_count_q   <= '0;
            rd_ptr_q       <= '0;
            lane0_q        <= '0;
            lane1_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            wr_bank_q      <= wr_bank_d;
            swap_pending_q <= swap_pending_d;
            prev_count_q   <= prev_count_d;
            rd_ptr_q       <= rd_ptr_d;
            lane0_q        <= lane0_d;
            lane1_q        <= lane1_d;
            done_q         <= done_d;
        end
    end

`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && !wr_acc) ovf_d = 1'b1;
        if (do_swap)          ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign wr_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_oflow_prev_frame_buffer_reader.sv
// Directed bench for oflow_prev_frame_buffer_reader.
// Covers OFLOW_PREV_BUF_OVF_FLAG_EN checks when that macro is defined.
module tb_oflow_prev_frame_buffer_reader;

    localparam int DEPTH = 32;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_frame_done;
    logic          wr_ready;
    logic          start_read;
    logic          ctrl;
    logic [DW-1:0] lane0;
    logic [DW-1:0] lane1;
    logic          done_read;
    logic [CW-1:0] prev_count;
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
    logic          wr_overflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    oflow_prev_frame_buffer_reader #(
        .DEPTH (DEPTH),
        .DATA_W(DW)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .wr_en                      (wr_en),
        .wr_data                    (wr_data),
        .wr_frame_done              (wr_frame_done),
        .wr_ready                   (wr_ready),
        .start_read                 (start_read),
        .control_for_read_new_line  (ctrl),
        .data_to_similarity_metric_0(lane0),
        .data_to_similarity_metric_1(lane1),
        .done_read                  (done_read),
        .prev_count                 (prev_count)
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        ,
        .wr_overflow                (wr_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] line(input int id);
        logic [7:0] b;
        b = 8'(id);
        return {8{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ids(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = line(first + i);
            tick();
        end
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic commit();
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
    endtask

    task automatic start();
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        tick();
    endtask

    task automatic request();
        ctrl = 1'b1;
        tick();
        ctrl = 1'b0;
        tick();
    endtask

    task automatic pair(input string tag, input int a, input int b,
                        input logic d);
        chk({tag, ".l0"}, lane0, line(a));
        chk({tag, ".l1"}, lane1, line(b));
        chk({tag, ".done"}, DW'(done_read), DW'(d));
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        wr_frame_done = 1'b0;
        start_read = 1'b0;
        ctrl = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        pair("rst", 0, 0, 1'b0);
        chk("rst.cnt", DW'(prev_count), 0);
        chk("rst.rdy", DW'(wr_ready), 1);
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        chk("rst.ovf", DW'(wr_overflow), 0);
`endif

        // Five lines, odd count leaves an empty lane-1 at the end.
        write_ids(1, 5);
        commit();
        chk("f5.cnt", DW'(prev_count), 5);
        start();
        pair("f5.p0", 1, 2, 1'b0);
        ctrl = 1'b1;
        tick();
        ctrl = 1'b0;
        pair("f5.hold", 1, 2, 1'b0);
        tick();
        pair("f5.p1", 3, 4, 1'b0);
        request();
        pair("f5.p2", 5, 0, 1'b1);
        request();
        pair("f5.idle", 5, 0, 1'b1);

        // Final line written in the same cycle as the commit.
        write_ids(7, 3);
        wr_en = 1'b1;
        wr_data = line(10);
        wr_frame_done = 1'b1;
        tick();
        wr_en = 1'b0;
        wr_frame_done = 1'b0;
        chk("f4.cnt", DW'(prev_count), 4);
        start();
        pair("f4.p0", 7, 8, 1'b0);
        request();
        pair("f4.p1", 9, 10, 1'b1);
        request();

        // Empty frame.
        commit();
        chk("f0.cnt", DW'(prev_count), 0);
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        chk("f0.t1.done", DW'(done_read), 0);
        tick();
        pair("f0.p0", 0, 0, 1'b1);
        request();

        // Overfill by three lines.
        write_ids(1, DEPTH + 3);
        chk("ovf.rdy", DW'(wr_ready), 1);
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        chk("ovf.pre", DW'(wr_overflow), 1);
`endif
        commit();
        chk("ovf.cnt", DW'(prev_count), DEPTH);
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        chk("ovf.post", DW'(wr_overflow), 0);
`endif
        start();
        pair("full.p0", 1, 2, 1'b0);

        // Commit while replay is presenting: swap must be deferred.
        write_ids(50, 3);
        commit();
        chk("def.rdy0", DW'(wr_ready), 0);
        wr_en = 1'b1;
        wr_data = line(99);
        tick();
        wr_en = 1'b0;
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        chk("def.ovf", DW'(wr_overflow), 1);
`endif
        chk("def.cnt0", DW'(prev_count), DEPTH);
        for (int k = 1; k < DEPTH / 2; k++) begin
            request();
            pair($sformatf("full.p%0d", k), 2 * k + 1, 2 * k + 2,
                 k == DEPTH / 2 - 1);
        end
        ctrl = 1'b1;
        tick();
        ctrl = 1'b0;
        chk("def.rdy1", DW'(wr_ready), 0);
        tick();
        chk("def.rdy2", DW'(wr_ready), 1);
        chk("def.cnt1", DW'(prev_count), 3);
`ifdef OFLOW_PREV_BUF_OVF_FLAG_EN
        chk("def.ovfclr", DW'(wr_overflow), 0);
`endif
        start();
        pair("new.p0", 50, 51, 1'b0);
        request();
        pair("new.p1", 52, 0, 1'b1);
        request();

        // Reset while presenting (3,4).
        write_ids(1, 5);
        commit();
        start();
        request();
        pair("mid.p1", 3, 4, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pair("mrst", 0, 0, 1'b0);
        chk("mrst.cnt", DW'(prev_count), 0);
        chk("mrst.rdy", DW'(wr_ready), 1);
        start();
        pair("mrst.p0", 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
